// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg -- shared arithmetic-core definitions.
//
// Holds the multiplier operation encoding (mul_mode_t), the divider's
// operation constants, and the operand-magnitude helper used by the multiplier.
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_WIDTH   = 32;
    localparam int MUL_COUNT_W = 6;   // holds 0..32

    // Multiplier operation, matching the encoding on the mode port.
    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,  // low word, unsigned x unsigned
        MODE_MULH   = 2'b01,  // high word, signed x signed
        MODE_MULHSU = 2'b10,  // high word, signed x unsigned
        MODE_MULHU  = 2'b11   // high word, unsigned x unsigned
    } mul_mode_t;

    // Divider operation constants (shared with the divider block).
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Magnitude of an operand: negated only when it is treated as signed and
    // negative. 0x80000000 maps to itself, which is the correct unsigned
    // magnitude 2^31.
    function automatic logic [MUL_WIDTH-1:0] operand_mag(
        input logic [MUL_WIDTH-1:0] value,
        input logic                 is_signed
    );
        if (is_signed && value[MUL_WIDTH-1])
            return ~value + 1'b1;
        else
            return value;
    endfunction

endpackage

// File: rtl/mul.sv
// -----------------------------------------------------------------------------
// mul -- 32-cycle shift-and-add multiplier supporting MUL/MULH/MULHSU/MULHU.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   kick         in   start request, accepted only while ready=1
//   mode         in   2-bit operation (see mul_mode_t)
//   multiplicand in   operand A (signed for MULH/MULHSU)
//   multiplier   in   operand B (signed for MULH only)
//   ready        out  idle / result valid
//   ready_pre    out  high the cycle before ready rises
//   product      out  64-bit sign-corrected product
//   result       out  low word for MUL, high word otherwise
//
// Operands are converted to magnitudes on kick; the unsigned magnitudes are
// multiplied over exactly 32 cycles and the sign is applied combinationally
// at the output, so product/result hold until the next accepted kick.
// -----------------------------------------------------------------------------
module mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               kick,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               ready_pre,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result
);

    // Registered state
    logic [MUL_COUNT_W-1:0] count_q,  count_d;
    logic [2*WIDTH-1:0]     acc_q,    acc_d;
    logic [WIDTH-1:0]       mag_a_q,  mag_a_d;
    logic [WIDTH-1:0]       mag_b_q,  mag_b_d;
    logic                   negate_q, negate_d;
    mul_mode_t              mode_q,   mode_d;

    // Operand decode for the incoming request
    mul_mode_t          mode_in;
    logic               a_signed;
    logic               b_signed;
    logic [2*WIDTH-1:0] addend;

    assign mode_in  = mul_mode_t'(mode);
    assign a_signed = (mode_in == MODE_MULH) || (mode_in == MODE_MULHSU);
    assign b_signed = (mode_in == MODE_MULH);

    // A-magnitude aligned to the weight of the current B bit. count runs
    // 32 down to 1, so the shift runs 0 up to 31; the 64-bit width keeps
    // every product bit.
    assign addend = {{WIDTH{1'b0}}, mag_a_q} << (MUL_COUNT_W'(WIDTH) - count_q);

    // NOTE: every always_comb target gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        negate_d = negate_q;
        mode_d   = mode_q;

        if (count_q == '0) begin
            // IDLE: results hold until a kick is accepted.
            if (kick) begin
                mag_a_d  = operand_mag(multiplicand, a_signed);
                mag_b_d  = operand_mag(multiplier,   b_signed);
                negate_d = (a_signed & multiplicand[WIDTH-1])
                         ^ (b_signed & multiplier[WIDTH-1]);
                mode_d   = mode_in;
                acc_d    = '0;
                count_d  = MUL_COUNT_W'(WIDTH);
            end
        end else begin
            // BUSY: one multiplier bit per cycle, no early exit.
            if (mag_b_q[0])
                acc_d = acc_q + addend;
            mag_b_d = mag_b_q >> 1;
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    // NOTE: the operand registers are reset too; it costs nothing here and
    // keeps the state fully defined after an aborted operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            acc_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            negate_q <= 1'b0;
            mode_q   <= MODE_MUL;
        end else begin
            count_q  <= count_d;
            acc_q    <= acc_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            negate_q <= negate_d;
            mode_q   <= mode_d;
        end
    end

    assign ready     = (count_q == '0);
    assign ready_pre = (count_q == MUL_COUNT_W'(1));
    assign product   = negate_q ? (~acc_q + 1'b1) : acc_q;
    assign result    = (mode_q == MODE_MUL) ? product[WIDTH-1:0]
                                            : product[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul.sv
// -----------------------------------------------------------------------------
// tb_mul -- scoreboard bench for mul.
//
// The driver issues operations and pushes the expected product/result plus
// the kick edge number into a queue; an independent monitor pops an entry
// each time ready rises and compares value, latency and ready_pre timing.
// -----------------------------------------------------------------------------
module tb_mul;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        kick = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        ready;
    logic        ready_pre;
    logic [63:0] product;
    logic [31:0] result;

    mul #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .kick         (kick),
        .mode         (mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .ready_pre    (ready_pre),
        .product      (product),
        .result       (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] product;
        logic [31:0] result;
        int          kick_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   in_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: true integer product of the operands as each mode
    // interprets them, reduced modulo 2^64.
    function automatic logic [63:0] ref_product(input logic [1:0] m,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa, sb;
        sa = (m == 2'b01 || m == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (m == 2'b01)               ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(sa * sb);
    endfunction

    function automatic logic [31:0] pick_result(input logic [1:0] m, input logic [63:0] p);
        return (m == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Monitor: compares on every rising edge of ready (sampled at negedge).
    logic prev_ready = 1'b1;
    logic prev_ready_pre = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!in_reset && ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("product",       product,           e.product);
                check("result",        64'(result),       64'(e.result));
                check("latency",       64'(cyc),          64'(e.kick_cyc + 32));
                check("ready_pre_lead",64'(prev_ready_pre), 64'(1));
            end
        end
        prev_ready     = ready;
        prev_ready_pre = ready_pre;
    end

    // Wait (bounded) until the DUT is idle, sampling on negedge.
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 64'(ready), 64'(1));
    endtask

    // Issue one operation; operands are scrambled after acceptance to show
    // that mid-operation input changes do not matter.
    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p_exp);
        exp_t e;
        wait_ready();
        mode = m; multiplicand = a; multiplier = b; kick = 1'b1;
        e.product  = p_exp;
        e.result   = pick_result(m, p_exp);
        e.kick_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        kick = 1'b0;
        mode = 2'($urandom); multiplicand = $urandom; multiplier = $urandom;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [1:0]  m;
        int          n;

        // Reset state
        #1;
        check("rst_ready",     64'(ready),     64'(1));
        check("rst_ready_pre", 64'(ready_pre), 64'(0));
        check("rst_product",   product,        64'(0));
        check("rst_result",    64'(result),    64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;

        // Directed vectors with hand-derived expectations
        issue(2'b00, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue(2'b00, 32'd0, 32'd0, 64'h0);

        // Kick while busy is ignored
        issue(2'b00, 32'd3, 32'd5, 64'd15);
        repeat (8) @(negedge clk);
        mode = 2'b00; multiplicand = 32'd9; multiplier = 32'd9; kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        wait_ready();
        // Result holds in IDLE
        repeat (3) @(negedge clk);
        check("hold_result",  64'(result), 64'd15);
        check("hold_product", product,     64'd15);
        check("hold_ready",   64'(ready),  64'(1));

        // Randomized vectors against the reference model
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom);
            a = rand_operand();
            b = rand_operand();
            issue(m, a, b, ref_product(m, a, b));
        end

        // Reset mid-operation aborts; outputs clear asynchronously
        wait_ready();
        mode = 2'b11; multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF; kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", 64'(ready), 64'(0));
        in_reset = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("abort_ready",     64'(ready),     64'(1));
        check("abort_ready_pre", 64'(ready_pre), 64'(0));
        check("abort_product",   product,        64'(0));
        check("abort_result",    64'(result),    64'(0));
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;

        // First operation after release is a full one
        issue(2'b01, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);

        // Drain scoreboard (bounded)
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 SHALL be supported.
REQ-002 Port: clk  input  1  rising-edge clock, the block's only clock.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: kick  input  1  start request, accepted only when ready=1.
REQ-005 Port: mode  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 Port: multiplicand  input  32  operand A, signed for MULH/MULHSU, else unsigned.
REQ-007 Port: multiplier  input  32  operand B, signed for MULH only, else unsigned.
REQ-008 Port: ready  output  1  idle / result valid.
REQ-009 Port: ready_pre  output  1  high exactly one cycle before ready rises.
REQ-010 Port: product  output  64  full sign-corrected product.
REQ-011 Port: result  output  32  product[31:0] for MUL, product[63:32] otherwise.

Function
REQ-012 Two states by 6-bit counter: IDLE (count=0), BUSY (count 1..32).
REQ-013 IDLE with kick=1: latch operand magnitudes, mode and negate flag; count<=32; accumulator<=0.
REQ-014 Magnitude: two's-complement negation of an operand only when it is treated as signed and its bit 31=1; 0x80000000 yields magnitude 0x80000000 (unsigned).
REQ-015 Negate flag = (A signed & A[31]) XOR (B signed & B[31]); MUL mode treats both as unsigned.
REQ-016 BUSY, each cycle: if B-magnitude LSB=1, accumulator += A-magnitude shifted left by (32-count); B-magnitude >>=1; count-=1.
REQ-017 Accumulator and shifted A SHALL be 64 bits; no bits discarded.
REQ-018 Latency: kick sampled at edge N -> ready=1 after edge N+32; ready_pre=1 during the cycle after edge N+31.
REQ-019 No early termination: zero or small operands still take 32 cycles.
REQ-020 product = negate flag ? two's complement of accumulator : accumulator, computed combinationally from registered state.
REQ-021 ready = (count==0); ready_pre = (count==1); both combinational from count.
REQ-022 kick while BUSY SHALL be ignored; operand/mode changes while BUSY SHALL not affect the result.
REQ-023 product/result SHALL hold their value in IDLE until the next accepted kick.
REQ-024 kick coincident with ready rising (same cycle count==0) SHALL be accepted.

Reset
REQ-025 reset_n=0 SHALL asynchronously force count=0, accumulator=0, negate flag=0.
REQ-026 Under reset: ready=1, ready_pre=0, product=0, result=0.
REQ-027 Reset mid-operation SHALL abort; first kick after release starts a full 32-cycle operation.

Structure
REQ-028 Mode encoding SHALL be an enum mul_mode_t in the shared core package, alongside the divider's operation constants.
REQ-029 Single module; no sub-module; adder is one 64-bit inferred add.

Verification
REQ-030 MUL 7 x 6 -> result=0x0000002A, product=0x00000000_0000002A; ready_pre one cycle before ready; ready 32 cycles after kick.
REQ-031 MULH 0xFFFFFFFF x 0x00000002 -> product=0xFFFFFFFF_FFFFFFFE, result=0xFFFFFFFF.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE_00000001, result=0xFFFFFFFE; MULHSU same operands -> product=0xFFFFFFFF_00000001, result=0xFFFFFFFF.
REQ-033 MULH 0x80000000 x 0x80000000 -> product=0x40000000_00000000, result=0x40000000.
REQ-034 Kick MUL 3x5, pulse kick with 9x9 at cycle 10 -> ignored, result=15 at cycle 32; then reset_n low at cycle 5 of new op -> ready=1, product=0 immediately.
